// File: rtl/counterdown16_1clk_posedge_async_resetn_pkg.sv
// Shared definitions for the loadable down counter: default width and FSM state encoding.
package counterdown16_1clk_posedge_async_resetn_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/counterdown16_1clk_posedge_async_resetn_if.sv
// Control/status bundle of the down counter; master drives controls, slave is the counter.
interface counterdown16_1clk_posedge_async_resetn_if #(
  parameter int WIDTH = 16
);
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             enable;
  logic             auto_reload;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             running;
  logic             done;

  modport master (
    output load, load_value, enable, auto_reload,
    input  count, tc, running, done
  );

  modport slave (
    input  load, load_value, enable, auto_reload,
    output count, tc, running, done
  );
endinterface

// File: rtl/counterdown16_1clk_posedge_async_resetn.sv
// Loadable down counter/timer with terminal-count pulse and optional auto-reload.
//
// state   | meaning
// IDLE    | no count in progress (after reset or a load of zero)
// RUN     | counting down while enable is high
// DONE    | one-shot finished, count parked at zero until the next load
module counterdown16_1clk_posedge_async_resetn
  import counterdown16_1clk_posedge_async_resetn_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic clock0,
  input  logic resetn,
  counterdown16_1clk_posedge_async_resetn_if.slave bus
);

  state_t           state;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] reload_q;
  logic             tc_q;

  always_ff @(posedge clock0 or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else if (bus.load) begin
      reload_q <= bus.load_value;
      count_q  <= bus.load_value;
      tc_q     <= 1'b0;
      state    <= (bus.load_value != '0) ? ST_RUN : ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (bus.enable) begin
            // RUN never holds zero, so count==1 is the only terminal case
            if (count_q == WIDTH'(1)) begin
              tc_q <= 1'b1;
              if (bus.auto_reload) begin
                count_q <= reload_q;
              end else begin
                count_q <= '0;
                state   <= ST_DONE;
              end
            end else begin
              count_q <= count_q - WIDTH'(1);
              tc_q    <= 1'b0;
            end
          end else begin
            tc_q <= 1'b0;
          end
        end
        default: begin
          tc_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.count   = count_q;
  assign bus.tc      = tc_q;
  assign bus.running = (state == ST_RUN);
  assign bus.done    = (state == ST_DONE);

endmodule
